ttt_game_controller: RTL

TTT_GAME_CONTROLLER -- requirements
Module: ttt_game_controller

---
 rtl/ttt_pkg.sv | 46 ++++
 rtl/ttt_line_checker.sv | 23 ++
 rtl/ttt_game_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe controller.
//   - cell codes (2 bits per board cell)
//   - externally reported game_state codes
//   - internal FSM state type
//   - NO_CELL cursor value and the 8-line winning table
package ttt_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;
  localparam int BOARD_W   = 2 * NUM_CELLS;

  // Cell codes; 2'b11 is never written to the board.
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  // Reported game_state codes.
  localparam logic [1:0] GS_PLAY  = 2'b00;
  localparam logic [1:0] GS_X_WIN = 2'b01;
  localparam logic [1:0] GS_O_WIN = 2'b10;
  localparam logic [1:0] GS_DRAW  = 2'b11;

  localparam logic [3:0] NO_CELL = 4'd15;

  typedef enum logic [2:0] {
    ST_PLAY,
    ST_CHECK,
    ST_X_WIN,
    ST_O_WIN,
    ST_DRAW
  } state_t;

  // Line table: LINE_TBL[line][k] is the k-th cell index of that line.
  // Listed from line 7 down to line 0 because the array is packed.
  localparam logic [NUM_LINES-1:0][2:0][3:0] LINE_TBL = {
    {4'd6, 4'd4, 4'd2},  // 7: anti-diagonal
    {4'd8, 4'd4, 4'd0},  // 6: diagonal
    {4'd8, 4'd5, 4'd2},  // 5: column 2
    {4'd7, 4'd4, 4'd1},  // 4: column 1
    {4'd6, 4'd3, 4'd0},  // 3: column 0
    {4'd8, 4'd7, 4'd6},  // 2: row 2
    {4'd5, 4'd4, 4'd3},  // 1: row 1
    {4'd2, 4'd1, 4'd0}   // 0: row 0
  };

endpackage

// File: rtl/ttt_line_checker.sv
// ttt_line_checker: combinational; flags every line whose three cells all
// hold the given player code.
//   board     : 18-bit board, cell i at [2i+1:2i]
//   code      : player code to test (CELL_X or CELL_O)
//   line_hit  : bit l set when line l is complete for code
module ttt_line_checker
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0]   board,
  input  logic [1:0]           code,
  output logic [NUM_LINES-1:0] line_hit
);

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    localparam int C0 = int'(LINE_TBL[l][0]);
    localparam int C1 = int'(LINE_TBL[l][1]);
    localparam int C2 = int'(LINE_TBL[l][2]);
    assign line_hit[l] = (board[2*C0 +: 2] == code) &&
                         (board[2*C1 +: 2] == code) &&
                         (board[2*C2 +: 2] == code);
  end

endmodule

// File: rtl/ttt_game_controller.sv
// ttt_game_controller: tic-tac-toe game FSM driven by a mouse cursor/click.
//   clk, rst_n   : clock, async active-low reset
//   chesspos     : cell under cursor (0..8, >8 = no cell)
//   click        : button level (synchronous)
//   restart      : start a new game (overrides a simultaneous press)
//   board        : 9 x 2-bit cells (00 empty, 01 X, 10 O)
//   turn         : player to move (0 X, 1 O)
//   game_state   : 00 play, 01 X win, 10 O win, 11 draw
//   win_line     : one-hot(ish) set of completed lines
//   move_count   : moves this game (0..9)
//   move_ok/rej  : one-cycle pulses for accepted / rejected presses
module ttt_game_controller
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           chesspos,
  input  logic                 click,
  input  logic                 restart,
  output logic [BOARD_W-1:0]   board,
  output logic                 turn,
  output logic [1:0]           game_state,
  output logic [NUM_LINES-1:0] win_line,
  output logic [3:0]           move_count,
  output logic                 move_ok,
  output logic                 move_rej
);

  state_t               state;
  logic                 click_q;
  logic                 press;
  logic [1:0]           turn_code;
  logic [1:0]           cur_cell;
  logic                 pos_valid;
  logic [NUM_LINES-1:0] line_hit;

  assign press     = click & ~click_q;
  assign turn_code = turn ? CELL_O : CELL_X;
  assign pos_valid = (chesspos <= 4'd8);

  // Cell under the cursor; reads as empty when the cursor is off-board,
  // which is harmless because pos_valid gates its use.
  always_comb begin
    cur_cell = CELL_EMPTY;
    for (int i = 0; i < NUM_CELLS; i++)
      if (chesspos == 4'(i)) cur_cell = board[2*i +: 2];
  end

  // The board register already holds the new mark while in ST_CHECK.
  ttt_line_checker u_line_checker (
    .board    (board),
    .code     (turn_code),
    .line_hit (line_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PLAY;
      click_q    <= 1'b1;  // a button held through reset must not fire
      board      <= '0;
      turn       <= FIRST_PLAYER;
      game_state <= GS_PLAY;
      win_line   <= '0;
      move_count <= '0;
      move_ok    <= 1'b0;
      move_rej   <= 1'b0;
    end else begin
      click_q  <= click;  // sampled even during restart
      move_ok  <= 1'b0;
      move_rej <= 1'b0;
      if (restart) begin
        state      <= ST_PLAY;
        board      <= '0;
        turn       <= FIRST_PLAYER;
        game_state <= GS_PLAY;
        win_line   <= '0;
        move_count <= '0;
      end else begin
        case (state)
          ST_PLAY: begin
            if (press) begin
              if (pos_valid && cur_cell == CELL_EMPTY) begin
                for (int i = 0; i < NUM_CELLS; i++)
                  if (chesspos == 4'(i)) board[2*i +: 2] <= turn_code;
                move_count <= move_count + 4'd1;
                move_ok    <= 1'b1;
                state      <= ST_CHECK;
              end else begin
                move_rej <= 1'b1;
              end
            end
          end
          ST_CHECK: begin
            if (|line_hit) begin
              win_line   <= line_hit;
              state      <= turn ? ST_O_WIN : ST_X_WIN;
              game_state <= turn ? GS_O_WIN : GS_X_WIN;
            end else if (move_count == 4'd9) begin
              state      <= ST_DRAW;
              game_state <= GS_DRAW;
            end else begin
              turn  <= ~turn;
              state <= ST_PLAY;
            end
          end
          default: ;  // terminal states hold until restart/reset
        endcase
      end
    end
  end

endmodule
